interrupt_source_ctrl: RTL and testbench

Peripheral-side interrupt initiator for the Atari system. It drives the CPU's `IRQ_L` and `NMI_L` pins from bus-mapped enable/status registers in the style of POKEY IRQEN/IRQST and ANTIC NMIEN/NMIST/NMIRES. It sits between the custom-chip event sources and the 6502C interrupt inputs, on the external data/address bus. It guarantees the NMI waveform the CPU's falling-edge NMI detector needs: a fixed low pulse followed by at least one high cycle.

---
 rtl/interrupt_source_ctrl_pkg.sv | 24 ++
 rtl/interrupt_source_ctrl_if.sv | 11 +
 rtl/interrupt_source_ctrl_nmi_pulse_gen.sv | 70 +++++++
 rtl/interrupt_source_ctrl.sv | 94 +++++++++
 tb/tb_interrupt_source_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_source_ctrl_pkg.sv
// Shared register offsets, NMIST bit positions and NMI pulse FSM encoding
// for the POKEY/ANTIC-style interrupt source block.
package interrupt_source_ctrl_pkg;

    localparam logic [1:0] IRQEN_A  = 2'd0;
    localparam logic [1:0] NMIEN_A  = 2'd1;
    localparam logic [1:0] NMIRES_A = 2'd2;

    localparam int unsigned NMI_DLI_b = 7;
    localparam int unsigned NMI_VBI_b = 6;
    localparam int unsigned NMI_RST_b = 5;

    // Bit positions of the NMI event lines on nmiSrc
    localparam int unsigned SRC_DLI = 0;
    localparam int unsigned SRC_VBI = 1;
    localparam int unsigned SRC_RST = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } nmi_state_t;

endpackage

// File: rtl/interrupt_source_ctrl_if.sv
// CPU-side register bus of the interrupt source block.
interface interrupt_source_ctrl_if;
    logic       cs;
    logic [1:0] addr;
    logic       nRW;
    logic [7:0] dataIn;
    logic [7:0] dataOut;

    modport master (output cs, addr, nRW, dataIn, input dataOut);
    modport slave  (input cs, addr, nRW, dataIn, output dataOut);
endinterface

// File: rtl/interrupt_source_ctrl_nmi_pulse_gen.sv
// NMI waveform generator: fixed-width low pulse, one high gap, one-slot
// queue so a trigger arriving mid-pulse produces a second pulse.
module nmi_pulse_gen
    import interrupt_source_ctrl_pkg::*;
#(
    parameter int unsigned NMI_PULSE = 2
) (
    input  logic phi1,
    input  logic rstAll,
    input  logic trigger,
    output logic NMI_L
);

    localparam int unsigned CNT_W = (NMI_PULSE > 1) ? $clog2(NMI_PULSE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NMI_PULSE - 1);

    nmi_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             queued_q, queued_d;
    logic             nmi_l_d;

    always_ff @(posedge phi1 or posedge rstAll) begin
        if (rstAll) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            queued_q <= 1'b0;
            NMI_L    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            queued_q <= queued_d;
            NMI_L    <= nmi_l_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        queued_d = queued_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = PULSE;
                    cnt_d   = CNT_LOAD;
                end
            end
            PULSE: begin
                queued_d = queued_q | trigger;
                if (cnt_q == '0) state_d = GAP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            GAP: begin
                // A trigger landing on the gap cycle itself is folded into the slot
                queued_d = 1'b0;
                if (queued_q || trigger) begin
                    state_d = PULSE;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nmi_l_d = (state_d != PULSE);
    end

endmodule

// File: rtl/interrupt_source_ctrl.sv
// IRQEN/IRQST and NMIEN/NMIST/NMIRES register block driving the 6502
// IRQ_L level and NMI_L pulse from custom-chip event lines.
module interrupt_source_ctrl
    import interrupt_source_ctrl_pkg::*;
#(
    parameter int unsigned NMI_PULSE = 2
) (
    input  logic                           phi1,
    input  logic                           rstAll,
    interrupt_source_ctrl_if.slave         bus,
    input  logic [7:0]                     irqSrc,
    input  logic [2:0]                     nmiSrc,
    output logic                           IRQ_L,
    output logic                           NMI_L
);

    logic [7:0] irq_prev_q, irq_ev;
    logic [2:0] nmi_prev_q, nmi_ev;
    logic [7:0] irqen_q, irqen_d, irqst_q, irqst_d;
    logic [7:0] nmist_q, nmist_d, nmi_set;
    logic       dli_en_q, dli_en_d, vbi_en_q, vbi_en_d;
    logic       wr, wr_irqen, wr_nmien, wr_nmires;
    logic       trigger;
    logic [7:0] rd_data;

    assign wr        = bus.cs & ~bus.nRW;
    assign wr_irqen  = wr & (bus.addr == IRQEN_A);
    assign wr_nmien  = wr & (bus.addr == NMIEN_A);
    assign wr_nmires = wr & (bus.addr == NMIRES_A);

    assign irq_ev = irqSrc & ~irq_prev_q;
    assign nmi_ev = nmiSrc & ~nmi_prev_q;

    // Events are qualified by the enables as they stood before any same-cycle write
    always_comb begin
        irqen_d = wr_irqen ? bus.dataIn : irqen_q;
        irqst_d = wr_irqen ? (irqst_q | ~bus.dataIn) : irqst_q;
        irqst_d = irqst_d & ~(irq_ev & irqen_q);

        dli_en_d = wr_nmien ? bus.dataIn[NMI_DLI_b] : dli_en_q;
        vbi_en_d = wr_nmien ? bus.dataIn[NMI_VBI_b] : vbi_en_q;

        nmi_set            = 8'h00;
        nmi_set[NMI_DLI_b] = nmi_ev[SRC_DLI] & dli_en_q;
        nmi_set[NMI_VBI_b] = nmi_ev[SRC_VBI] & vbi_en_q;
        nmi_set[NMI_RST_b] = nmi_ev[SRC_RST];
        nmist_d = wr_nmires ? nmi_set : (nmist_q | nmi_set);
    end

    assign trigger = |nmi_set;

    always_ff @(posedge phi1 or posedge rstAll) begin
        if (rstAll) begin
            irq_prev_q <= 8'h00;
            nmi_prev_q <= 3'b000;
            irqen_q    <= 8'h00;
            irqst_q    <= 8'hFF;
            dli_en_q   <= 1'b0;
            vbi_en_q   <= 1'b0;
            nmist_q    <= 8'h00;
            IRQ_L      <= 1'b1;
        end else begin
            irq_prev_q <= irqSrc;
            nmi_prev_q <= nmiSrc;
            irqen_q    <= irqen_d;
            irqst_q    <= irqst_d;
            dli_en_q   <= dli_en_d;
            vbi_en_q   <= vbi_en_d;
            nmist_q    <= nmist_d;
            IRQ_L      <= ~|(~irqst_d & irqen_d);
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (bus.cs && bus.nRW) begin
            case (bus.addr)
                IRQEN_A: rd_data = irqst_q;
                NMIEN_A: rd_data = nmist_q;
                default: rd_data = 8'h00;
            endcase
        end
    end

    assign bus.dataOut = rd_data;

    nmi_pulse_gen #(.NMI_PULSE(NMI_PULSE)) u_nmi_pulse_gen (
        .phi1    (phi1),
        .rstAll  (rstAll),
        .trigger (trigger),
        .NMI_L   (NMI_L)
    );

endmodule

// File: tb/tb_interrupt_source_ctrl.sv
// Scoreboard bench for interrupt_source_ctrl: expectations are queued with
// the stimulus and popped as register reads and pin samples come back.
module tb_interrupt_source_ctrl;
    import interrupt_source_ctrl_pkg::*;

    logic       phi1;
    logic       rstAll;
    logic [7:0] irqSrc;
    logic [2:0] nmiSrc;
    logic       IRQ_L;
    logic       NMI_L;

    interrupt_source_ctrl_if bus();

    interrupt_source_ctrl #(.NMI_PULSE(2)) dut (
        .phi1   (phi1),
        .rstAll (rstAll),
        .bus    (bus),
        .irqSrc (irqSrc),
        .nmiSrc (nmiSrc),
        .IRQ_L  (IRQ_L),
        .NMI_L  (NMI_L)
    );

    initial phi1 = 1'b0;
    always #5 phi1 = ~phi1;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got, exp;

    task automatic tick();
        @(posedge phi1);
        @(negedge phi1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.cs = 1'b1; bus.nRW = 1'b0; bus.addr = a; bus.dataIn = d;
        tick();
        bus.cs = 1'b0; bus.nRW = 1'b1; bus.dataIn = 8'h00;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        bus.cs = 1'b1; bus.nRW = 1'b1; bus.addr = a;
        #1;
        v = bus.dataOut;
        bus.cs = 1'b0;
    endtask

    task automatic test_reset();
        wr(IRQEN_A, 8'hFF);
        irqSrc = 8'h01; nmiSrc = 3'b100;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        tick();
        got = {7'b0, IRQ_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL pre_reset_irq_l: got %h expected %h", got, exp); end
        got = {7'b0, NMI_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL pre_reset_nmi_l: got %h expected %h", got, exp); end
        #2 rstAll = 1'b1;
        exp_q.push_back(8'h01); exp_q.push_back(8'h01); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        #1;
        got = {7'b0, NMI_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_nmi_l: got %h expected %h", got, exp); end
        got = {7'b0, IRQ_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_irq_l: got %h expected %h", got, exp); end
        rd(IRQEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_irqst: got %h expected %h", got, exp); end
        rd(NMIEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_nmist: got %h expected %h", got, exp); end
        @(negedge phi1);
        irqSrc = 8'h00; nmiSrc = 3'b000; rstAll = 1'b0;
        tick();
    endtask

    task automatic test_irq_enable();
        wr(IRQEN_A, 8'h40);
        exp_q.push_back(8'h01);
        got = {7'b0, IRQ_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irq_l_enabled_idle: got %h expected %h", got, exp); end
        irqSrc[6] = 1'b1;
        exp_q.push_back(8'hBF); exp_q.push_back(8'h00);
        tick();
        irqSrc[6] = 1'b0;
        rd(IRQEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irqst_after_event: got %h expected %h", got, exp); end
        got = {7'b0, IRQ_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irq_l_after_event: got %h expected %h", got, exp); end
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
        wr(IRQEN_A, 8'h00);
        rd(IRQEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irqst_after_disable: got %h expected %h", got, exp); end
        got = {7'b0, IRQ_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irq_l_after_disable: got %h expected %h", got, exp); end
    endtask

    task automatic test_irq_masked();
        irqSrc[3] = 1'b1;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
        tick();
        rd(IRQEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL masked_irqst: got %h expected %h", got, exp); end
        got = {7'b0, IRQ_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL masked_irq_l: got %h expected %h", got, exp); end
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
        wr(IRQEN_A, 8'h08);
        tick(); tick();
        rd(IRQEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL held_line_irqst: got %h expected %h", got, exp); end
        got = {7'b0, IRQ_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL held_line_irq_l: got %h expected %h", got, exp); end
        irqSrc[3] = 1'b0;
        tick();
        irqSrc[3] = 1'b1;
        exp_q.push_back(8'hF7); exp_q.push_back(8'h00);
        tick();
        rd(IRQEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rearmed_irqst: got %h expected %h", got, exp); end
        got = {7'b0, IRQ_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rearmed_irq_l: got %h expected %h", got, exp); end
        irqSrc[3] = 1'b0;
        wr(IRQEN_A, 8'h00);
    endtask

    task automatic test_nmi_pulse();
        wr(NMIEN_A, 8'hC0);
        nmiSrc[SRC_VBI] = 1'b1;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) nmiSrc = 3'b000;
            got = {7'b0, NMI_L}; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL nmi_pulse_cyc%0d: got %h expected %h", i, got, exp); end
        end
        exp_q.push_back(8'h40);
        rd(NMIEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL nmist_vbi: got %h expected %h", got, exp); end
        exp_q.push_back(8'h00);
        wr(NMIRES_A, 8'h5A);
        rd(NMIEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL nmist_after_nmires: got %h expected %h", got, exp); end
    endtask

    task automatic test_queued_nmi();
        nmiSrc[SRC_VBI] = 1'b1;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) nmiSrc = 3'b001;
            if (i == 1) nmiSrc = 3'b000;
            got = {7'b0, NMI_L}; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL queued_nmi_cyc%0d: got %h expected %h", i, got, exp); end
        end
        exp_q.push_back(8'hC0);
        rd(NMIEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL nmist_queued: got %h expected %h", got, exp); end
    endtask

    task automatic test_simultaneous();
        wr(NMIEN_A, 8'h00);
        nmiSrc[SRC_RST] = 1'b1;
        bus.cs = 1'b1; bus.nRW = 1'b0; bus.addr = NMIRES_A; bus.dataIn = 8'hFF;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                bus.cs = 1'b0; bus.nRW = 1'b1; bus.dataIn = 8'h00; nmiSrc = 3'b000;
            end
            got = {7'b0, NMI_L}; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin errors++; $display("FAIL rst_key_nmi_cyc%0d: got %h expected %h", i, got, exp); end
        end
        exp_q.push_back(8'h20);
        rd(NMIEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL nmist_nmires_vs_rst: got %h expected %h", got, exp); end

        // Enabled bit: same-cycle disable write and event, the event's clear wins
        wr(IRQEN_A, 8'h10);
        irqSrc[4] = 1'b1;
        exp_q.push_back(8'hEF); exp_q.push_back(8'h01);
        wr(IRQEN_A, 8'h00);
        irqSrc[4] = 1'b0;
        rd(IRQEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irqst_clear_wins: got %h expected %h", got, exp); end
        got = {7'b0, IRQ_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irq_l_clear_wins: got %h expected %h", got, exp); end

        // Already-disabled bit: event is masked, the disable write keeps it 1
        irqSrc[2] = 1'b1;
        exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
        wr(IRQEN_A, 8'h00);
        irqSrc[2] = 1'b0;
        rd(IRQEN_A, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irqst_masked_bit_stays: got %h expected %h", got, exp); end
        got = {7'b0, IRQ_L}; exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL irq_l_masked_bit_stays: got %h expected %h", got, exp); end
    endtask

    task automatic test_unmapped();
        exp_q.push_back(8'h00);
        wr(2'd3, 8'hA5);
        rd(2'd3, got); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL offset3_read: got %h expected %h", got, exp); end
        exp_q.push_back(8'h00);
        checks++;
        if (exp_q.size() != 1) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 1", exp_q.size()); end
        exp = exp_q.pop_front();
        bus.cs = 1'b0; bus.nRW = 1'b1; bus.addr = IRQEN_A;
        #1;
        checks++;
        if (bus.dataOut !== exp) begin errors++; $display("FAIL idle_bus_read: got %h expected %h", bus.dataOut, exp); end
    endtask

    initial begin
        rstAll = 1'b1;
        irqSrc = 8'h00; nmiSrc = 3'b000;
        bus.cs = 1'b0; bus.nRW = 1'b1; bus.addr = 2'd0; bus.dataIn = 8'h00;
        repeat (2) @(negedge phi1);
        rstAll = 1'b0;
        tick();
        test_reset();
        test_irq_enable();
        test_irq_masked();
        test_nmi_pulse();
        test_queued_nmi();
        test_simultaneous();
        test_unmapped();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
